regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources: ALU and MEM (load).

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter for the register file write port
module regfile_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int REG_ID_W   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_ID_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_ID_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   wr_en,
    output logic [REG_ID_W-1:0]    wr_reg,
    output logic [DATA_W-1:0]      wr_data,
    output logic [2**REG_ID_W-1:0] pend_mask
);

    localparam logic [3:0] SC_MAX = 4'(STARVE_MAX);

    logic                ha_v;
    logic [REG_ID_W-1:0] ha_reg;
    logic [DATA_W-1:0]   ha_data;
    logic                hm_v;
    logic [REG_ID_W-1:0] hm_reg;
    logic [DATA_W-1:0]   hm_data;
    logic [3:0]          sc;

    logic grant_a;
    logic grant_m;
    logic alu_acc;
    logic mem_acc;

    // ALU wins only when MEM is idle or ALU has lost STARVE_MAX times in a row
    always_comb begin
        grant_a = ha_v & (!hm_v | (sc == SC_MAX));
        grant_m = hm_v & !grant_a;
    end

    // Write port, ready and pending mask; all forced quiet while reset is asserted
    always_comb begin
        wr_en     = 1'b0;
        wr_reg    = '0;
        wr_data   = '0;
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        pend_mask = '0;
        if (rst_n) begin
            wr_en     = ha_v | hm_v;
            alu_ready = !ha_v | grant_a;
            mem_ready = !hm_v | grant_m;
            if (grant_a) begin
                wr_reg  = ha_reg;
                wr_data = ha_data;
            end else if (grant_m) begin
                wr_reg  = hm_reg;
                wr_data = hm_data;
            end
            if (ha_v) pend_mask[ha_reg] = 1'b1;
            if (hm_v) pend_mask[hm_reg] = 1'b1;
        end
    end

    assign alu_acc = alu_valid & alu_ready;
    assign mem_acc = mem_valid & mem_ready;

    // Holding entries: refill on accept, drain on grant, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ha_v    <= 1'b0;
            hm_v    <= 1'b0;
            ha_reg  <= '0;
            ha_data <= '0;
            hm_reg  <= '0;
            hm_data <= '0;
        end else begin
            if (alu_acc) begin
                ha_v    <= 1'b1;
                ha_reg  <= alu_reg;
                ha_data <= alu_data;
            end else if (grant_a) begin
                ha_v <= 1'b0;
            end
            if (mem_acc) begin
                hm_v    <= 1'b1;
                hm_reg  <= mem_reg;
                hm_data <= mem_data;
            end else if (grant_m) begin
                hm_v <= 1'b0;
            end
        end
    end

    // Starvation counter: counts ALU losses under contention, cleared by an ALU grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc <= '0;
        end else if (grant_a) begin
            sc <= '0;
        end else if (ha_v && grant_m && (sc < SC_MAX)) begin
            sc <= sc + 4'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic [15:0] pend_mask;

    int checks;
    int errors;

    regfile_wb_arbiter #(.DATA_W(16), .REG_ID_W(4), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge, then let inputs be changed
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] r,
                            input logic [15:0] d, input logic [15:0] pm);
        check({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, en});
        check({tag, ".wr_reg"}, {28'd0, wr_reg}, {28'd0, r});
        check({tag, ".wr_data"}, {16'd0, wr_data}, {16'd0, d});
        check({tag, ".pend"}, {16'd0, pend_mask}, {16'd0, pm});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_reg   = 4'd5;
        alu_data  = 16'h1234;
        mem_valid = 1'b0;
        mem_reg   = 4'd0;
        mem_data  = 16'h0;

        // 1: reset held two edges with a request offered
        #1;
        sample();
        check_wr("rst0", 1'b0, 4'd0, 16'h0, 16'h0);
        check("rst0.alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst0.mem_ready", {31'd0, mem_ready}, 32'd0);
        next_cycle();
        sample();
        check_wr("rst1", 1'b0, 4'd0, 16'h0, 16'h0);
        next_cycle();
        rst_n     = 1'b1;
        alu_valid = 1'b0;
        sample();
        check_wr("rel", 1'b0, 4'd0, 16'h0, 16'h0);
        check("rel.alu_ready", {31'd0, alu_ready}, 32'd1);
        check("rel.mem_ready", {31'd0, mem_ready}, 32'd1);

        // 2: single ALU write
        alu_valid = 1'b1;
        alu_reg   = 4'd5;
        alu_data  = 16'hBEEF;
        next_cycle();
        alu_valid = 1'b0;
        sample();
        check_wr("alu1", 1'b1, 4'd5, 16'hBEEF, 16'h0020);
        next_cycle();
        sample();
        check_wr("alu1.idle", 1'b0, 4'd0, 16'h0, 16'h0);

        // 3: simultaneous requests, MEM first
        alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'h2222;
        next_cycle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        sample();
        check_wr("both.c1", 1'b1, 4'd7, 16'h2222, 16'h0088);
        check("both.c1.alu_ready", {31'd0, alu_ready}, 32'd0);
        next_cycle();
        sample();
        check_wr("both.c2", 1'b1, 4'd3, 16'h1111, 16'h0008);
        next_cycle();
        sample();
        check_wr("both.c3", 1'b0, 4'd0, 16'h0, 16'h0);

        // 4: starvation, ALU held while MEM streams
        alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'hA001;
        mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 16'hD000;
        next_cycle();
        alu_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            mem_data = 16'hD000 + 16'(i);
            sample();
            check_wr($sformatf("starve.m%0d", i), 1'b1, 4'd2, 16'hD000 + 16'(i - 1), 16'h0006);
            check($sformatf("starve.m%0d.mem_ready", i), {31'd0, mem_ready}, 32'd1);
            next_cycle();
        end
        mem_data = 16'hD004;
        sample();
        check_wr("starve.a", 1'b1, 4'd1, 16'hA001, 16'h0006);
        check("starve.a.mem_ready", {31'd0, mem_ready}, 32'd0);
        next_cycle();
        mem_valid = 1'b0;
        sample();
        check_wr("starve.m4", 1'b1, 4'd2, 16'hD003, 16'h0004);
        next_cycle();
        sample();
        check_wr("starve.idle", 1'b0, 4'd0, 16'h0, 16'h0);

        // 5: MEM streaming alone, one write per cycle
        for (int i = 0; i <= 8; i++) begin
            mem_valid = (i < 8);
            mem_reg   = 4'(i + 8);
            mem_data  = 16'h5000 + 16'(i);
            sample();
            if (i < 8) check($sformatf("mstream%0d.ready", i), {31'd0, mem_ready}, 32'd1);
            if (i > 0) check_wr($sformatf("mstream%0d", i), 1'b1, 4'(i + 7),
                                16'h5000 + 16'(i - 1), 16'h1 << (i + 7));
            next_cycle();
        end
        sample();
        check_wr("mstream.idle", 1'b0, 4'd0, 16'h0, 16'h0);

        // same destination from both sources, register 0: two writes in grant order
        alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 16'h0A0A;
        mem_valid = 1'b1; mem_reg = 4'd0; mem_data = 16'h0B0B;
        next_cycle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        sample();
        check_wr("same.c1", 1'b1, 4'd0, 16'h0B0B, 16'h0001);
        next_cycle();
        sample();
        check_wr("same.c2", 1'b1, 4'd0, 16'h0A0A, 16'h0001);
        next_cycle();
        sample();
        check_wr("same.idle", 1'b0, 4'd0, 16'h0, 16'h0);

        // 6: reset with both entries full discards them
        alu_valid = 1'b1; alu_reg = 4'd4; alu_data = 16'h4444;
        mem_valid = 1'b1; mem_reg = 4'd9; mem_data = 16'h9999;
        next_cycle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst_n     = 1'b0;
        sample();
        check_wr("rstfull.during", 1'b0, 4'd0, 16'h0, 16'h0);
        next_cycle();
        rst_n = 1'b1;
        sample();
        check_wr("rstfull.after", 1'b0, 4'd0, 16'h0, 16'h0);
        check("rstfull.alu_ready", {31'd0, alu_ready}, 32'd1);
        check("rstfull.mem_ready", {31'd0, mem_ready}, 32'd1);
        next_cycle();
        sample();
        check_wr("rstfull.later", 1'b0, 4'd0, 16'h0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
